// File: rtl/gpi_irq_ctrl.sv
// gpi_irq_ctrl: synchronised GPI with sticky per-bit rise/fall status and a level IRQ.
// Define GPI_IRQ_DEBOUNCE_EN to build the per-bit debounce counters and DEBOUNCE register.
module gpi_irq_ctrl #(
    parameter int GpiWidth      = 8,
    parameter int DebounceWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    input  logic [GpiWidth-1:0] gp_i,
    output logic                irq_o
);
    localparam logic [2:0] IdxValue    = 3'd0;
    localparam logic [2:0] IdxRiseEn   = 3'd1;
    localparam logic [2:0] IdxFallEn   = 3'd2;
    localparam logic [2:0] IdxStatus   = 3'd3;
    localparam logic [2:0] IdxDebounce = 3'd4;

    function automatic logic [GpiWidth-1:0] f_merge_gpi(input logic [GpiWidth-1:0] old,
                                                        input logic [31:0] wd,
                                                        input logic [3:0] be);
        logic [GpiWidth-1:0] res;
        for (int i = 0; i < GpiWidth; i++) res[i] = be[i/8] ? wd[i] : old[i];
        return res;
    endfunction

    function automatic logic [GpiWidth-1:0] f_w1c_gpi(input logic [31:0] wd,
                                                      input logic [3:0] be);
        logic [GpiWidth-1:0] res;
        for (int i = 0; i < GpiWidth; i++) res[i] = be[i/8] & wd[i];
        return res;
    endfunction

    logic [2:0]          w_idx;
    logic                w_wr;
    logic                w_rd;
    logic                w_unused_addr;
    logic [GpiWidth-1:0] r_sync1, r_sync2, r_stable;
    logic [GpiWidth-1:0] w_stable_next;
    logic [GpiWidth-1:0] r_rise_en, r_fall_en, r_status;
    logic [GpiWidth-1:0] w_rise, w_fall, w_set, w_clr;
    logic [31:0]         w_deb_rd;
    logic [31:0]         w_rdata;
    logic                r_rvalid;
    logic [31:0]         r_rdata;

    assign w_idx         = device_addr_i[4:2];
    assign w_wr          = device_req_i & device_we_i;
    assign w_rd          = device_req_i & ~device_we_i;
    assign w_unused_addr = ^{device_addr_i[31:5], device_addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
        end else begin
            r_sync1  <= gp_i;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
        end
    end

`ifdef GPI_IRQ_DEBOUNCE_EN
    function automatic logic [DebounceWidth-1:0] f_merge_deb(input logic [DebounceWidth-1:0] old,
                                                             input logic [31:0] wd,
                                                             input logic [3:0] be);
        logic [DebounceWidth-1:0] res;
        for (int i = 0; i < DebounceWidth; i++) res[i] = be[i/8] ? wd[i] : old[i];
        return res;
    endfunction

    logic [DebounceWidth-1:0]               r_debounce;
    logic [GpiWidth-1:0][DebounceWidth-1:0] r_cnt, w_cnt_next;

    // >= so that lowering the limit below a running count flips on the next compare
    always_comb begin
        w_stable_next = r_stable;
        w_cnt_next    = r_cnt;
        for (int i = 0; i < GpiWidth; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] >= r_debounce) begin
                w_stable_next[i] = r_sync2[i];
                w_cnt_next[i]    = '0;
            end else begin
                w_cnt_next[i] = r_cnt[i] + DebounceWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_debounce <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_wr && w_idx == IdxDebounce)
                r_debounce <= f_merge_deb(r_debounce, device_wdata_i, device_be_i);
        end
    end

    always_comb begin
        w_deb_rd                      = '0;
        w_deb_rd[DebounceWidth-1:0]   = r_debounce;
    end
`else
    assign w_stable_next = r_sync2;
    assign w_deb_rd      = '0;
`endif

    assign w_rise = w_stable_next & ~r_stable;
    assign w_fall = ~w_stable_next & r_stable;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (w_wr && w_idx == IdxStatus) ? f_w1c_gpi(device_wdata_i, device_be_i) : '0;

    // Set is OR'd after the clear so a same-cycle event survives a W1C
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
            if (w_wr && w_idx == IdxRiseEn)
                r_rise_en <= f_merge_gpi(r_rise_en, device_wdata_i, device_be_i);
            if (w_wr && w_idx == IdxFallEn)
                r_fall_en <= f_merge_gpi(r_fall_en, device_wdata_i, device_be_i);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            IdxValue:    w_rdata[GpiWidth-1:0] = r_stable;
            IdxRiseEn:   w_rdata[GpiWidth-1:0] = r_rise_en;
            IdxFallEn:   w_rdata[GpiWidth-1:0] = r_fall_en;
            IdxStatus:   w_rdata[GpiWidth-1:0] = r_status;
            IdxDebounce: w_rdata = w_deb_rd;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= device_req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign irq_o           = |(r_status & (r_rise_en | r_fall_en));

endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// Randomised bench for gpi_irq_ctrl: a sample-history reference model checked every cycle,
// plus directed literal checks on latency, glitch rejection, W1C and byte enables.
`timescale 1ns/1ps
module tb_gpi_irq_ctrl;
    localparam int GW = 8;
`ifdef GPI_IRQ_DEBOUNCE_EN
    localparam bit         DEB      = 1'b1;
    localparam int         LAT      = 7;
    localparam logic [7:0] PULSE_ST = 8'h01;
`else
    localparam bit         DEB      = 1'b0;
    localparam int         LAT      = 3;
    localparam logic [7:0] PULSE_ST = 8'h09;
`endif

    logic          clk, rst_n, req, we, rvalid, irq;
    logic [31:0]   addr, wdata, rdata;
    logic [3:0]    be;
    logic [GW-1:0] gp;
    int            n_tot = 0;
    int            n_bad = 0;

    gpi_irq_ctrl #(.GpiWidth(GW), .DebounceWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
        .device_be_i(be), .device_wdata_i(wdata),
        .device_rvalid_o(rvalid), .device_rdata_o(rdata),
        .gp_i(gp), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stable flips once the last DEBOUNCE+1 synchronised samples all differ
    logic [GW-1:0] m_s1, m_s2, m_stable, m_re, m_fe, m_st;
    logic [15:0]   m_deb;
    logic          m_rvalid;
    logic [31:0]   m_rdata;
    logic [GW-1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_re = '0; m_fe = '0; m_st = '0;
            m_deb = '0; m_rvalid = 1'b0; m_rdata = '0;
            hist.delete();
        end else begin
            logic [GW-1:0] nxt, setv, clr, wm;
            int            need;
            bit            diff;
            m_rvalid = req;
            m_rdata  = '0;
            if (req && !we) begin
                case (addr[4:2])
                    3'd0: m_rdata = 32'(m_stable);
                    3'd1: m_rdata = 32'(m_re);
                    3'd2: m_rdata = 32'(m_fe);
                    3'd3: m_rdata = 32'(m_st);
                    3'd4: m_rdata = DEB ? 32'(m_deb) : 32'd0;
                    default: m_rdata = '0;
                endcase
            end
            hist.push_back(m_s2);
            if (hist.size() > 64) void'(hist.pop_front());
            need = DEB ? int'(m_deb) + 1 : 1;
            nxt  = m_stable;
            for (int i = 0; i < GW; i++) begin
                if (hist.size() >= need) begin
                    diff = 1'b1;
                    for (int k = hist.size() - need; k < hist.size(); k++)
                        if (hist[k][i] == m_stable[i]) diff = 1'b0;
                    if (diff) nxt[i] = ~m_stable[i];
                end
            end
            setv = ((nxt & ~m_stable) & m_re) | ((~nxt & m_stable) & m_fe);
            clr  = '0;
            for (int i = 0; i < GW; i++) wm[i] = be[i/8];
            if (req && we) begin
                case (addr[4:2])
                    3'd1: m_re = (m_re & ~wm) | (wdata[GW-1:0] & wm);
                    3'd2: m_fe = (m_fe & ~wm) | (wdata[GW-1:0] & wm);
                    3'd3: clr  = wdata[GW-1:0] & wm;
                    3'd4: if (DEB) for (int i = 0; i < 16; i++) if (be[i/8]) m_deb[i] = wdata[i];
                    default: ;
                endcase
            end
            m_st     = (m_st & ~clr) | setv;
            m_s2     = m_s1;
            m_s1     = gp;
            m_stable = nxt;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
            chk("rdata", rdata, m_rdata);
            chk("irq", {31'd0, irq}, {31'd0, |(m_st & (m_re | m_fe))});
        end
    end

    task automatic wr(input int idx, input logic [3:0] b, input logic [31:0] d);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'(idx) << 2; be = b; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [31:0] d, output logic rv);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'(idx) << 2; be = 4'hF; wdata = '0;
        @(posedge clk); #1;
        req = 1'b0;
        d = rdata; rv = rvalid;
    endtask

    initial begin
        logic [31:0] d;
        logic        rv;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; gp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(i, d, rv);
            chk("reset_read", d, 32'd0);
            chk("reset_read_rvalid", {31'd0, rv}, 32'd1);
        end

        // Steady rise on bit 0: IRQ exactly LAT cycles after the pin edge
        wr(4, 4'hF, 32'd4);
        wr(1, 4'hF, 32'h01);
        @(posedge clk); #1; gp[0] = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("irq_before_lat", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 chk("irq_at_lat", {31'd0, irq}, 32'd1);
        rd(0, d, rv); chk("value_rise", d, 32'h01);
        rd(3, d, rv); chk("status_rise", d, 32'h01);

        // 3-cycle pulse on bit 3
        wr(1, 4'hF, 32'h09);
        @(posedge clk); #1; gp[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1 gp[3] = 1'b0;
        repeat (12) @(posedge clk);
        rd(0, d, rv); chk("value_pulse", d, 32'h01);
        rd(3, d, rv); chk("status_pulse", d, 32'(PULSE_ST));

        // Fall-only enable on bit 7, then W1C
        wr(3, 4'hF, 32'hFF);
        wr(2, 4'hF, 32'h80);
        @(posedge clk); #1; gp[7] = 1'b1;
        repeat (12) @(posedge clk);
        #1 gp[7] = 1'b0;
        repeat (12) @(posedge clk);
        rd(3, d, rv); chk("status_fall", d, 32'h80);
        chk("irq_fall", {31'd0, irq}, 32'd1);
        wr(3, 4'hF, 32'h80);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);
        rd(3, d, rv); chk("status_after_w1c", d, 32'h00);

        // W1C of bit 2 on the same edge as a new rise: set wins
        wr(1, 4'hF, 32'h0D);
        @(posedge clk); #1; gp[2] = 1'b1;
        repeat (12) @(posedge clk);
        rd(3, d, rv); chk("status_bit2", d, 32'h04);
        wr(3, 4'hF, 32'h04);
        gp[2] = 1'b0;
        repeat (12) @(posedge clk);
        #1 gp[2] = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 req = 1'b1; we = 1'b1; addr = 32'h0C; be = 4'hF; wdata = 32'h04;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0;
        rd(3, d, rv); chk("status_set_wins", d, 32'h04);

        // Byte enables on RISE_EN
        wr(1, 4'hF, 32'h0);
        wr(1, 4'b0010, 32'hFFFF_FFFF);
        rd(1, d, rv); chk("rise_en_be1", d, 32'h0);
        wr(1, 4'b0001, 32'hFFFF_FFFF);
        rd(1, d, rv); chk("rise_en_be0", d, 32'hFF);

        // Random traffic with occasional reset
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n = (c % 500 != 250);
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = $urandom_range(0, GW - 1);
                gp[b] = ~gp[b];
            end
            req   = ($urandom_range(0, 1) == 1);
            we    = ($urandom_range(0, 2) == 0);
            addr  = $urandom;
            be    = 4'($urandom_range(0, 15));
            wdata = (addr[4:2] == 3'd4) ? 32'($urandom_range(0, 6)) : $urandom;
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
